// File: rtl/switch_input_pkg.sv
// rtl/switch_input_pkg.sv - shared types and helpers for the switch input scanner
package switch_input_pkg;

  // Kind values double as bit positions inside each channel's pending vector.
  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    LONG    = 2'd2
  } event_kind_t;

  localparam int EVENT_KIND_COUNT = 3;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_input_scanner_if.sv
// rtl/switch_input_scanner_if.sv - valid/ready event stream between scanner and consumer
interface switch_input_scanner_if #(
  parameter int NUM_SWITCHES = 4
);
  import switch_input_pkg::*;

  localparam int IDX_W = idx_width(NUM_SWITCHES);

  logic             event_valid;
  logic             event_ready;
  logic [IDX_W-1:0] event_index;
  event_kind_t      event_kind;

  modport master (
    output event_valid,
    output event_index,
    output event_kind,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_index,
    input  event_kind,
    output event_ready
  );

endinterface

// File: rtl/switch_channel.sv
// rtl/switch_channel.sv - one switch: synchroniser, debounce filter, hold timer, pending events
module switch_channel
  import switch_input_pkg::*;
#(
  parameter int FILTER_COUNTER_MAX   = 3,
  parameter int LONG_PRESS_TICKS     = 500,
  parameter int SYNCHRONIZE_FF_DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        async_in,
  input  logic                        sample_tick,
  input  logic [EVENT_KIND_COUNT-1:0] clear_pending,
  output logic                        level_out,
  output logic [EVENT_KIND_COUNT-1:0] pending,
  output logic                        overflow_pulse
);

  localparam int FILT_W = (FILTER_COUNTER_MAX > 0) ? $clog2(FILTER_COUNTER_MAX + 1) : 1;
  localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);

  logic [SYNCHRONIZE_FF_DEPTH-1:0] sync_q;
  logic                            synced;
  logic [FILT_W-1:0]               filt_q, filt_d;
  logic                            level_q, level_d;
  logic [HOLD_W-1:0]               hold_q, hold_d;
  logic [EVENT_KIND_COUNT-1:0]     pend_q, pend_d;
  logic [EVENT_KIND_COUNT-1:0]     post;

  assign synced         = sync_q[SYNCHRONIZE_FF_DEPTH-1];
  assign level_out      = level_q;
  assign pending        = pend_q;
  // A post only loses an event when the bit is still set after this cycle's clear.
  assign overflow_pulse = |(post & pend_q & ~clear_pending);

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNCHRONIZE_FF_DEPTH-2:0], async_in};
    end
  end

  // Debounce filter, hold timer and event posting, evaluated on sample ticks only.
  always_comb begin
    filt_d  = filt_q;
    level_d = level_q;
    hold_d  = hold_q;
    post    = '0;
    if (sample_tick) begin
      if (synced != level_q) begin
        if (filt_q < FILT_W'(FILTER_COUNTER_MAX)) begin
          filt_d = filt_q + FILT_W'(1);
        end else begin
          filt_d  = '0;
          level_d = ~level_q;
          if (level_q) begin
            post[RELEASE] = 1'b1;
          end else begin
            post[PRESS] = 1'b1;
          end
        end
      end else begin
        filt_d = '0;
      end
      if (!level_q && level_d) begin
        hold_d = '0;
      end else if (level_q && level_d && (hold_q < HOLD_W'(LONG_PRESS_TICKS))) begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(LONG_PRESS_TICKS - 1)) begin
          post[LONG] = 1'b1;
        end
      end
    end
    // Set wins over a same-cycle clear so a freshly posted event is never dropped.
    pend_d = (pend_q & ~clear_pending) | post;
  end

  // Channel state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q  <= '0;
      level_q <= 1'b0;
      hold_q  <= '0;
      pend_q  <= '0;
    end else begin
      filt_q  <= filt_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: rtl/switch_input_scanner.sv
// rtl/switch_input_scanner.sv - prescaler, per-channel debounce and round-robin event serialiser
module switch_input_scanner
  import switch_input_pkg::*;
#(
  parameter int NUM_SWITCHES         = 4,
  parameter int SAMPLE_DIVIDER       = 10000,
  parameter int FILTER_COUNTER_MAX   = 3,
  parameter int LONG_PRESS_TICKS     = 500,
  parameter int SYNCHRONIZE_FF_DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SWITCHES-1:0]   async_in,
  output logic [NUM_SWITCHES-1:0]   level_out,
  switch_input_scanner_if.master    ev,
  output logic                      overflow,
  input  logic                      clear_overflow
);

  localparam int IDX_W = idx_width(NUM_SWITCHES);
  localparam int PRE_W = $clog2(SAMPLE_DIVIDER);

  logic [PRE_W-1:0]            presc_q, presc_d;
  logic                        sample_tick;

  logic [EVENT_KIND_COUNT-1:0] pending       [NUM_SWITCHES];
  logic [EVENT_KIND_COUNT-1:0] clear_pending [NUM_SWITCHES];
  logic [NUM_SWITCHES-1:0]     ovf_pulse;

  logic [IDX_W-1:0]            rr_q, rr_d;
  int                          cand;
  logic [IDX_W-1:0]            cand_idx;
  logic                        grant_any;
  logic [IDX_W-1:0]            grant_idx;
  logic [EVENT_KIND_COUNT-1:0] grant_pend;
  event_kind_t                 grant_kind;
  logic                        load;

  logic                        valid_q, valid_d;
  logic [IDX_W-1:0]            index_q, index_d;
  event_kind_t                 kind_q, kind_d;
  logic                        overflow_q, overflow_d;

  assign sample_tick    = (presc_q == PRE_W'(SAMPLE_DIVIDER - 1));
  assign ev.event_valid = valid_q;
  assign ev.event_index = index_q;
  assign ev.event_kind  = kind_q;
  assign overflow       = overflow_q;

  // Free-running prescaler that wraps after SAMPLE_DIVIDER cycles.
  always_comb begin
    presc_d = sample_tick ? '0 : presc_q + PRE_W'(1);
  end

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_ch
    switch_channel #(
      .FILTER_COUNTER_MAX  (FILTER_COUNTER_MAX),
      .LONG_PRESS_TICKS    (LONG_PRESS_TICKS),
      .SYNCHRONIZE_FF_DEPTH(SYNCHRONIZE_FF_DEPTH)
    ) u_channel (
      .clock         (clock),
      .reset         (reset),
      .async_in      (async_in[g]),
      .sample_tick   (sample_tick),
      .clear_pending (clear_pending[g]),
      .level_out     (level_out[g]),
      .pending       (pending[g]),
      .overflow_pulse(ovf_pulse[g])
    );
  end

  // Round-robin search from rr_q for the first channel with anything pending.
  always_comb begin
    cand      = 0;
    cand_idx  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_SWITCHES; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NUM_SWITCHES) begin
        cand = cand - NUM_SWITCHES;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_any && (|pending[cand_idx])) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Kind priority PRESS > LONG > RELEASE keeps one press cycle in chronological order.
  always_comb begin
    grant_pend = pending[grant_idx];
    grant_kind = PRESS;
    if (grant_pend[PRESS]) begin
      grant_kind = PRESS;
    end else if (grant_pend[LONG]) begin
      grant_kind = LONG;
    end else if (grant_pend[RELEASE]) begin
      grant_kind = RELEASE;
    end
  end

  // Output register load, pending-bit clear, pointer advance and sticky overflow.
  always_comb begin
    load = grant_any && (!valid_q || ev.event_ready);
    for (int i = 0; i < NUM_SWITCHES; i++) begin
      clear_pending[i] = '0;
    end
    rr_d    = rr_q;
    valid_d = valid_q;
    index_d = index_q;
    kind_d  = kind_q;
    if (load) begin
      clear_pending[grant_idx][grant_kind] = 1'b1;
      rr_d    = (grant_idx == IDX_W'(NUM_SWITCHES - 1)) ? '0 : grant_idx + IDX_W'(1);
      valid_d = 1'b1;
      index_d = grant_idx;
      kind_d  = grant_kind;
    end else if (ev.event_ready) begin
      valid_d = 1'b0;
    end
    // A new overflow in the same cycle as the clear request keeps the flag set.
    overflow_d = (overflow_q && !clear_overflow) || (|ovf_pulse);
  end

  // Top-level state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      rr_q       <= '0;
      valid_q    <= 1'b0;
      index_q    <= '0;
      kind_q     <= PRESS;
      overflow_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      rr_q       <= rr_d;
      valid_q    <= valid_d;
      index_q    <= index_d;
      kind_q     <= kind_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_switch_input_scanner.sv
// tb/tb_switch_input_scanner.sv - directed self-checking bench for switch_input_scanner
module tb_switch_input_scanner;
  import switch_input_pkg::*;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FLT = 3;
  localparam int LNG = 5;

  logic         clock;
  logic         reset;
  logic [N-1:0] async_in;
  logic [N-1:0] level_out;
  logic         overflow;
  logic         clear_overflow;

  switch_input_scanner_if #(.NUM_SWITCHES(N)) ev ();

  switch_input_scanner #(
    .NUM_SWITCHES        (N),
    .SAMPLE_DIVIDER      (DIV),
    .FILTER_COUNTER_MAX  (FLT),
    .LONG_PRESS_TICKS    (LNG),
    .SYNCHRONIZE_FF_DEPTH(2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .async_in      (async_in),
    .level_out     (level_out),
    .ev            (ev),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int idx;
    int kind;
    int cyc;
  } evt_t;

  evt_t evq[$];
  evt_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every accepted event with the cycle it was handed over.
  always @(negedge clock) begin
    if (!reset && ev.event_valid && ev.event_ready) begin
      mon_e.idx  = int'(ev.event_index);
      mon_e.kind = int'(ev.event_kind);
      mon_e.cyc  = cyc;
      evq.push_back(mon_e);
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_level(input string tag, input int ch, input logic val, output int cycles);
    cycles = 0;
    while (level_out[ch] !== val && cycles < 60) begin
      step(1);
      cycles++;
    end
    if (level_out[ch] !== val) check_eq(tag, int'(level_out[ch]), int'(val));
  endtask

  task automatic expect_evt(input string tag, input int pos, input int idx, input int kind);
    int obs;
    obs = (pos < evq.size()) ? (evq[pos].idx * 4 + evq[pos].kind) : -1;
    check_eq(tag, obs, idx * 4 + kind);
  endtask

  int c;
  int bad;
  int sv, si, sk;

  initial begin
    reset          = 1'b1;
    async_in       = '0;
    clear_overflow = 1'b0;
    ev.event_ready = 1'b0;
    step(3);
    check_eq("rst_level", int'(level_out), 0);
    check_eq("rst_valid", int'(ev.event_valid), 0);
    check_eq("rst_index", int'(ev.event_index), 0);
    check_eq("rst_kind", int'(ev.event_kind), 0);
    check_eq("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    step(2);

    // Round-robin from reset: ch0, ch2, ch3 pressed together, then released together.
    ev.event_ready = 1'b1;
    evq.delete();
    async_in = 4'b1101;
    wait_level("rr_press_wait", 0, 1'b1, c);
    check_eq("rr_levels", int'(level_out), 13);
    async_in = 4'b0000;
    wait_level("rr_release_wait", 0, 1'b0, c);
    step(10);
    check_eq("rr_count", evq.size(), 6);
    expect_evt("rr_ev0", 0, 0, 0);
    expect_evt("rr_ev1", 1, 2, 0);
    expect_evt("rr_ev2", 2, 3, 0);
    expect_evt("rr_ev3", 3, 0, 1);
    expect_evt("rr_ev4", 4, 2, 1);
    expect_evt("rr_ev5", 5, 3, 1);
    if (evq.size() >= 3) begin
      check_eq("rr_b2b_1", evq[1].cyc - evq[0].cyc, 1);
      check_eq("rr_b2b_2", evq[2].cyc - evq[1].cyc, 1);
    end

    // Clean press/release on ch1 with LONG after 5 held ticks.
    evq.delete();
    async_in[1] = 1'b1;
    wait_level("clean_press_wait", 1, 1'b1, c);
    check_eq("clean_latency_window", (c >= 15 && c <= 18) ? 1 : 0, 1);
    check_eq("clean_valid_same_edge", int'(ev.event_valid), 0);
    step(1);
    check_eq("clean_valid_next", int'(ev.event_valid), 1);
    check_eq("clean_index_next", int'(ev.event_index), 1);
    check_eq("clean_kind_next", int'(ev.event_kind), 0);
    step(119);
    async_in[1] = 1'b0;
    wait_level("clean_release_wait", 1, 1'b0, c);
    step(10);
    check_eq("clean_count", evq.size(), 3);
    expect_evt("clean_press", 0, 1, 0);
    expect_evt("clean_long", 1, 1, 2);
    expect_evt("clean_release", 2, 1, 1);
    if (evq.size() >= 2) check_eq("clean_long_delay", evq[1].cyc - evq[0].cyc, LNG * DIV);

    // Pointer now sits after ch1: simultaneous ch0+ch2 must serve ch2 first.
    evq.delete();
    async_in = 4'b0101;
    wait_level("rr2_press_wait", 0, 1'b1, c);
    async_in = 4'b0000;
    wait_level("rr2_release_wait", 0, 1'b0, c);
    step(10);
    check_eq("rr2_count", evq.size(), 4);
    expect_evt("rr2_ev0", 0, 2, 0);
    expect_evt("rr2_ev1", 1, 0, 0);
    expect_evt("rr2_ev2", 2, 2, 1);
    expect_evt("rr2_ev3", 3, 0, 1);

    // Bounce: ch0 toggles every 2 ticks, never enough to pass the filter.
    evq.delete();
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      async_in[0] = ((i / 8) % 2 == 0);
      step(1);
      if (level_out[0] !== 1'b0) bad++;
    end
    async_in[0] = 1'b0;
    step(40);
    check_eq("bounce_level_changes", bad, 0);
    check_eq("bounce_events", evq.size(), 0);

    // Backpressure: PRESS on ch1 held stable while not ready, accepted once.
    ev.event_ready = 1'b0;
    evq.delete();
    async_in[1] = 1'b1;
    wait_level("bp_press_wait", 1, 1'b1, c);
    async_in[1] = 1'b0;
    step(2);
    sv = int'(ev.event_valid);
    si = int'(ev.event_index);
    sk = int'(ev.event_kind);
    check_eq("bp_valid", sv, 1);
    check_eq("bp_index", si, 1);
    check_eq("bp_kind", sk, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (int'(ev.event_valid) != sv || int'(ev.event_index) != si || int'(ev.event_kind) != sk) bad++;
    end
    check_eq("bp_stable", bad, 0);
    check_eq("bp_released_level", int'(level_out[1]), 0);
    check_eq("bp_no_accept", evq.size(), 0);
    ev.event_ready = 1'b1;
    step(10);
    check_eq("bp_count", evq.size(), 2);
    expect_evt("bp_press_once", 0, 1, 0);
    expect_evt("bp_release", 1, 1, 1);
    check_eq("bp_no_overflow", int'(overflow), 0);

    // Overflow: ch2 press, release, press, release, press while not ready.
    ev.event_ready = 1'b0;
    evq.delete();
    for (int k = 0; k < 5; k++) begin
      async_in[2] = (k % 2 == 0);
      wait_level("ovf_toggle_wait", 2, (k % 2 == 0), c);
    end
    check_eq("ovf_set", int'(overflow), 1);
    ev.event_ready = 1'b1;
    step(40);
    async_in[2] = 1'b0;
    wait_level("ovf_release_wait", 2, 1'b0, c);
    step(10);
    check_eq("ovf_count", evq.size(), 5);
    expect_evt("ovf_ev0", 0, 2, 0);
    expect_evt("ovf_ev1", 1, 2, 0);
    expect_evt("ovf_ev2", 2, 2, 1);
    expect_evt("ovf_ev3", 3, 2, 2);
    expect_evt("ovf_ev4", 4, 2, 1);
    check_eq("ovf_sticky", int'(overflow), 1);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    check_eq("ovf_cleared", int'(overflow), 0);

    // Asynchronous reset while an event is waiting on the output.
    ev.event_ready = 1'b0;
    evq.delete();
    async_in[3] = 1'b1;
    wait_level("ar_press_wait", 3, 1'b1, c);
    step(2);
    check_eq("ar_valid_before", int'(ev.event_valid), 1);
    check_eq("ar_index_before", int'(ev.event_index), 3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_level", int'(level_out), 0);
    check_eq("ar_valid", int'(ev.event_valid), 0);
    check_eq("ar_index", int'(ev.event_index), 0);
    check_eq("ar_kind", int'(ev.event_kind), 0);
    check_eq("ar_overflow", int'(overflow), 0);
    step(1);
    reset = 1'b0;
    ev.event_ready = 1'b1;
    wait_level("ar_repress_wait", 3, 1'b1, c);
    check_eq("ar_no_early_event", evq.size(), 0);
    step(5);
    check_eq("ar_count", evq.size(), 1);
    expect_evt("ar_press", 0, 3, 0);
    async_in[3] = 1'b0;
    wait_level("ar_release_wait", 3, 1'b0, c);
    step(10);
    expect_evt("ar_release", 1, 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
